bundle_pingpong_loader: RTL

BUNDLE_PINGPONG_LOADER -- requirements
Module: bundle_pingpong_loader

---
 rtl/bundle_pingpong_loader.sv | 89 ++++++++
 1 files changed

// File: rtl/bundle_pingpong_loader.sv
// Two-bank ping-pong loader: the producer fills one 3-lane bank while the
// consumer reads the other committed bank.
module bundle_pingpong_loader #(
  parameter int LANE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [LANE_W-1:0] in_data,
  output logic              in_ready,
  output logic [LANE_W-1:0] bank0_0,
  output logic [LANE_W-1:0] bank0_1,
  output logic [LANE_W-1:0] bank0_2,
  output logic [LANE_W-1:0] bank1_0,
  output logic [LANE_W-1:0] bank1_1,
  output logic [LANE_W-1:0] bank1_2,
  output logic              sel,
  output logic              out_valid,
  input  logic              consume,
  output logic              commit
);

  logic [LANE_W-1:0] bank_q [2][3];
  logic [LANE_W-1:0] bank_d [2][3];
  logic              wbank_q, wbank_d;
  logic              rbank_q, rbank_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        full_q, full_d;
  logic              commit_q, commit_d;
  logic              xfer;

  assign in_ready  = !full_q[wbank_q];
  assign xfer      = in_valid && in_ready;
  assign out_valid = full_q[rbank_q];
  assign sel       = rbank_q;
  assign commit    = commit_q;

  assign bank0_0 = bank_q[0][0];
  assign bank0_1 = bank_q[0][1];
  assign bank0_2 = bank_q[0][2];
  assign bank1_0 = bank_q[1][0];
  assign bank1_1 = bank_q[1][1];
  assign bank1_2 = bank_q[1][2];

  // The write side only touches a non-full bank and the read side only clears
  // a full one, so a commit and a consume on the same edge never collide.
  always_comb begin
    bank_d   = bank_q;
    wbank_d  = wbank_q;
    rbank_d  = rbank_q;
    lane_d   = lane_q;
    full_d   = full_q;
    commit_d = 1'b0;
    if (xfer) begin
      bank_d[wbank_q][lane_q] = in_data;
      if (lane_q == 2'd2) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = !wbank_q;
        lane_d          = 2'd0;
        commit_d        = 1'b1;
      end else begin
        lane_d = lane_q + 2'd1;
      end
    end
    if (consume && full_q[rbank_q]) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = !rbank_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q   <= '{default: '{default: '0}};
      wbank_q  <= 1'b0;
      rbank_q  <= 1'b0;
      lane_q   <= 2'd0;
      full_q   <= 2'b00;
      commit_q <= 1'b0;
    end else begin
      bank_q   <= bank_d;
      wbank_q  <= wbank_d;
      rbank_q  <= rbank_d;
      lane_q   <= lane_d;
      full_q   <= full_d;
      commit_q <= commit_d;
    end
  end

endmodule
